// File: rtl/pixel_burst_ctrl.sv
// pixel_burst_ctrl
//   Burst controller that moves up to MAX_BURST 8-bit pixels between the
//   pixel arrays and a 24-bit SRAM. Each SRAM access is held for
//   ACCESS_CYCLES cycles. Consecutive accesses are separated by one idle GAP
//   cycle. A one-cycle DONE state ends every burst.
//
//   Optional feature: define PIXCTRL_GRAYSCALE_EN to convert each read
//   {R,G,B} word to a grayscale pixel. When it is undefined, the pixel is
//   r_data[7:0].
//
//   All outputs are registered. The next-state logic also computes the
//   output values for the state being entered, so each output register
//   always matches the current state.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start, op     burst request, 0 = read / 1 = write
//   base_addr     first SRAM address of the burst
//   burst_len     pixel count, valid range 1..MAX_BURST
//   wr_pix        pixels to write, index 0 first
//   rd_pix        pixels read, index 0 first
//   busy          burst in progress (ACCESS and GAP)
//   done          one-cycle completion pulse
//   err           one-cycle pulse for a rejected burst length
//   address       SRAM address
//   w_data        SRAM write data
//   r_data        SRAM read data {R,G,B}
//   read_enable   SRAM read strobe
//   write_enable  SRAM write strobe
module pixel_burst_ctrl #(
  parameter int ADDR_BITS     = 16,
  parameter int MAX_BURST     = 20,
  parameter int ACCESS_CYCLES = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             op,
  input  logic [ADDR_BITS-1:0]             base_addr,
  input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len,
  input  logic [MAX_BURST-1:0][7:0]        wr_pix,
  output logic [MAX_BURST-1:0][7:0]        rd_pix,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [ADDR_BITS-1:0]             address,
  output logic [23:0]                      w_data,
  input  logic [23:0]                      r_data,
  output logic                             read_enable,
  output logic                             write_enable
);

  localparam int LEN_W = $clog2(MAX_BURST + 1);
  // Wide enough to hold ACCESS_CYCLES itself, so the increment on the final
  // access cycle never wraps.
  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                    state_r, state_n;
  logic [LEN_W-1:0]          idx_r, idx_n, len_r, len_n;
  logic [CNT_W-1:0]          cnt_r, cnt_n;
  logic                      op_r, op_n;
  logic [ADDR_BITS-1:0]      base_r, base_n;
  logic [ADDR_BITS-1:0]      address_r, address_n;
  logic [23:0]               w_data_r, w_data_n;
  logic                      busy_r, busy_n, done_r, done_n, err_r, err_n;
  logic                      re_r, re_n, we_r, we_n;
  logic [MAX_BURST-1:0][7:0] rd_pix_r;

  logic                      len_ok_s;
  logic                      last_cyc_s;
  logic [LEN_W-1:0]          idx_inc_s;
  logic                      rd_load_s;
  logic [7:0]                conv_pix_s;

`ifdef PIXCTRL_GRAYSCALE_EN
  // Approximate luma: s*(1/4+1/16+1/64+1/256) ~= s/3. The maximum result is 251.
  function automatic logic [7:0] gray_of(input logic [23:0] rgb);
    logic [9:0] s;
    s = 10'(rgb[23:16]) + 10'(rgb[15:8]) + 10'(rgb[7:0]);
    return 8'((s >> 4'd2) + (s >> 4'd4) + (s >> 4'd6) + (s >> 4'd8));
  endfunction

  assign conv_pix_s = gray_of(r_data);
`else
  // Only the blue byte is used here. The upper bytes are tied off on purpose.
  logic unused_rdata_s;
  assign unused_rdata_s = ^r_data[23:8];
  assign conv_pix_s     = r_data[7:0];
`endif

  assign len_ok_s   = (burst_len != {LEN_W{1'b0}}) && (burst_len <= LEN_W'(MAX_BURST));
  assign last_cyc_s = (cnt_r == CNT_W'(ACCESS_CYCLES - 1));
  assign idx_inc_s  = idx_r + LEN_W'(1'b1);

  // Next-state logic, plus the output values for the state being entered.
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    cnt_n     = cnt_r;
    op_n      = op_r;
    base_n    = base_r;
    len_n     = len_r;
    address_n = address_r;
    w_data_n  = w_data_r;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    re_n      = 1'b0;
    we_n      = 1'b0;
    rd_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len_ok_s) begin
            state_n   = ACCESS;
            op_n      = op;
            base_n    = base_addr;
            len_n     = burst_len;
            idx_n     = {LEN_W{1'b0}};
            cnt_n     = {CNT_W{1'b0}};
            address_n = base_addr;
            busy_n    = 1'b1;
            re_n      = ~op;
            we_n      = op;
            if (op) begin
              w_data_n = {3{wr_pix[0]}};
            end else begin
              w_data_n = w_data_r;
            end
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        cnt_n     = cnt_r + CNT_W'(1'b1);
        rd_load_s = last_cyc_s & ~op_r;
        if (last_cyc_s) begin
          if (idx_r == len_r - LEN_W'(1'b1)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = GAP;
            busy_n  = 1'b1;
          end
        end else begin
          busy_n = 1'b1;
          re_n   = ~op_r;
          we_n   = op_r;
          if (op_r) begin
            w_data_n = {3{wr_pix[idx_r]}};
          end else begin
            w_data_n = w_data_r;
          end
        end
      end
      GAP: begin
        state_n   = ACCESS;
        idx_n     = idx_inc_s;
        cnt_n     = {CNT_W{1'b0}};
        // The sum wraps modulo 2^ADDR_BITS.
        address_n = base_r + ADDR_BITS'(idx_inc_s);
        busy_n    = 1'b1;
        re_n      = ~op_r;
        we_n      = op_r;
        if (op_r) begin
          w_data_n = {3{wr_pix[idx_inc_s]}};
        end else begin
          w_data_n = w_data_r;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, burst context and registered outputs. Reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= {LEN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 1'b0;
      base_r    <= {ADDR_BITS{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      address_r <= {ADDR_BITS{1'b0}};
      w_data_r  <= 24'h000000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      re_r      <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      cnt_r     <= cnt_n;
      op_r      <= op_n;
      base_r    <= base_n;
      len_r     <= len_n;
      address_r <= address_n;
      w_data_r  <= w_data_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      err_r     <= err_n;
      re_r      <= re_n;
      we_r      <= we_n;
    end
  end

  // Read pixel store. Only entries below burst_len are ever written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pix_r <= '0;
    end else if (rd_load_s) begin
      rd_pix_r[idx_r] <= conv_pix_s;
    end
  end

  assign rd_pix       = rd_pix_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign address      = address_r;
  assign w_data       = w_data_r;
  assign read_enable  = re_r;
  assign write_enable = we_r;

endmodule

// File: tb/tb_pixel_burst_ctrl.sv
// Testbench for pixel_burst_ctrl.
//   For each burst, a behavioural model builds a queue with one expected
//   output record per cycle, using simple burst arithmetic. A single compare
//   process checks the DUT outputs against that queue on every falling edge.
//   When the queue is empty, the idle expectation is used instead. Literal
//   checks pin the conversion results and the burst latency.
module tb_pixel_burst_ctrl;

  logic              clk = 1'b0;
  logic              rst, start, op;
  logic [15:0]       base_addr;
  logic [4:0]        burst_len;
  logic [19:0][7:0]  wr_pix, rd_pix;
  logic              busy, done, err, read_enable, write_enable;
  logic [15:0]       address;
  logic [23:0]       w_data, r_data;
  bit                rd_fixed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc = -1;
  int start_cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit          busy, re, we, done, err;
    logic [15:0] addr;
    logic [23:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] last_addr;
  logic [23:0] last_wd;
  logic [7:0]  exp_rd[20];

  always #5 clk = ~clk;

  // SRAM stand-in: a fixed word, or a word derived from the address.
  assign r_data = rd_fixed ? 24'h306090 :
                  {address[7:0] ^ 8'hC3, address[15:8] + 8'h11, address[7:0] + 8'h5A};

  pixel_burst_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .base_addr(base_addr),
    .burst_len(burst_len), .wr_pix(wr_pix), .rd_pix(rd_pix), .busy(busy),
    .done(done), .err(err), .address(address), .w_data(w_data), .r_data(r_data),
    .read_enable(read_enable), .write_enable(write_enable)
  );

  function automatic logic [23:0] rgb_of(input logic [15:0] a);
    return {a[7:0] ^ 8'hC3, a[15:8] + 8'h11, a[7:0] + 8'h5A};
  endfunction

  function automatic logic [7:0] pix_of(input logic [23:0] rgb);
`ifdef PIXCTRL_GRAYSCALE_EN
    int s;
    s = int'(rgb[23:16]) + int'(rgb[15:8]) + int'(rgb[7:0]);
    return 8'((s / 4 + s / 16 + s / 64 + s / 256) % 256);
`else
    return rgb[7:0];
`endif
  endfunction

  function automatic exp_t mk(bit b, bit r, bit w, bit d, bit e, logic [15:0] a, logic [23:0] wd);
    exp_t x;
    x.busy = b; x.re = r; x.we = w; x.done = d; x.err = e; x.addr = a; x.wd = wd;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Per-cycle comparison against the model's expected record.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_addr, last_wd);
      chk("busy", busy, e.busy);
      chk("read_enable", read_enable, e.re);
      chk("write_enable", write_enable, e.we);
      chk("done", done, e.done);
      chk("err", err, e.err);
      chk("address", address, e.addr);
      chk("w_data", w_data, e.wd);
      if (done === 1'b1) done_cyc = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic chk_rd_all(input string nm);
    for (int i = 0; i < 20; i++) chk(nm, rd_pix[i], exp_rd[i]);
  endtask

  // One burst request in cycle 0. Optionally, a second start in cycle 3 that
  // must be ignored. exp_lat = 0 skips the literal latency check.
  task automatic run_burst(input bit wr, input logic [15:0] base, input int len,
                           input bit poke, input int exp_lat);
    logic [15:0] a;
    logic [23:0] wd;
    bit          ok;
    @(posedge clk); #1;
    start = 1'b1; op = wr; base_addr = base; burst_len = len[4:0];
    start_cyc = cyc;
    done_cyc = -1;
    ok = (len >= 1) && (len <= 20);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_addr, last_wd));
    if (!ok) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_addr, last_wd));
    end else begin
      wd = last_wd;
      for (int i = 0; i < len; i++) begin
        a = base + 16'(i);
        if (wr) wd = {3{wr_pix[i]}};
        for (int c = 0; c < 12; c++) exp_q.push_back(mk(1'b1, !wr, wr, 1'b0, 1'b0, a, wd));
        if (i < len - 1) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, wd));
        else             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, wd));
        if (!wr) exp_rd[i] = pix_of(rd_fixed ? 24'h306090 : rgb_of(a));
      end
      last_addr = base + 16'(len - 1);
      last_wd = wd;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; op = !wr; base_addr = 16'h5555; burst_len = 5'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    #1;
    chk_rd_all("rd_pix");
    if (exp_lat > 0) chk("latency", done_cyc - start_cyc, exp_lat);
    else chk("no_done", done_cyc, -1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; base_addr = 16'h0000; burst_len = 5'd0;
    wr_pix = '0; rd_fixed = 1'b1;
    for (int i = 0; i < 20; i++) exp_rd[i] = 8'h00;
    last_addr = 16'h0000; last_wd = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_re", read_enable, 1'b0);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_address", address, 16'h0000);
    chk("rst_w_data", w_data, 24'h000000);
    chk_rd_all("rst_rd_pix");
    rst = 1'b0;
    chk_en = 1'b1;

    // Single-pixel read of a fixed word.
    run_burst(1'b0, 16'h0100, 1, 1'b0, 13);
`ifdef PIXCTRL_GRAYSCALE_EN
    chk("rd_pix0_literal", rd_pix[0], 8'h5F);
`else
    chk("rd_pix0_literal", rd_pix[0], 8'h90);
`endif

    // Three-pixel write.
    wr_pix[0] = 8'hAB; wr_pix[1] = 8'h12; wr_pix[2] = 8'hFF;
    run_burst(1'b1, 16'h0200, 3, 1'b0, 39);
    chk("w_data_final_literal", w_data, 24'hFFFFFF);

    // Address wrap, with a start during the burst that must be ignored.
    rd_fixed = 1'b0;
    run_burst(1'b0, 16'hFFFF, 2, 1'b1, 26);
    chk("wrap_addr_literal", address, 16'h0000);

    // Rejected lengths.
    run_burst(1'b0, 16'h0000, 0, 1'b0, 0);
    run_burst(1'b0, 16'h0040, 21, 1'b0, 0);

    // Full-length read, then a short read that must leave upper entries alone.
    run_burst(1'b0, 16'h1234, 20, 1'b0, 260);
    run_burst(1'b0, 16'h2000, 5, 1'b0, 65);

    // Reset in cycle 5 of a 4-pixel read.
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; base_addr = 16'h0300; burst_len = 5'd4;
    done_cyc = -1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_addr, last_wd));
    for (int c = 0; c < 5; c++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, last_wd));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    last_addr = 16'h0000; last_wd = 24'h000000;
    for (int i = 0; i < 20; i++) exp_rd[i] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_rd_all("rst_mid_rd_pix");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cyc, -1);

    // A new burst is accepted after the reset.
    run_burst(1'b0, 16'h0300, 1, 1'b0, 13);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_burst_ctrl.md
PIXEL_BURST_CTRL -- requirements
Module: pixel_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16: SRAM address width.
REQ-002 SHALL have parameter MAX_BURST, default 20: maximum pixels per burst.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 12, minimum 1: cycles each SRAM access is held.
REQ-004 SHALL have a single clock and a synchronous, active-high reset, with ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  burst request.
- op  in  1  0 = read, 1 = write.
- base_addr  in  ADDR_BITS  first address.
- burst_len  in  $clog2(MAX_BURST+1)  pixel count.
- wr_pix  in  MAX_BURST x 8  pixels to write, index 0 first.
- rd_pix  out  MAX_BURST x 8  pixels read.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle bad-length pulse.
- address  out  ADDR_BITS  SRAM address.
- w_data  out  24  SRAM write data.
- r_data  in  24  SRAM read data, {R,G,B}.
- read_enable  out  1  SRAM read strobe.
- write_enable  out  1  SRAM write strobe.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, GAP, DONE.
REQ-006 IDLE, start=1, 1<=burst_len<=MAX_BURST: SHALL latch op, base_addr and burst_len, clear pixel index and wait counter, and go to ACCESS.
REQ-007 IDLE, start=1, burst_len=0 or burst_len>MAX_BURST: SHALL pulse err for one cycle, stay in IDLE, and perform no SRAM access.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 ACCESS SHALL drive address=base+idx modulo 2^ADDR_BITS, assert busy, and assert read_enable (op=0) or write_enable (op=1), never both.
REQ-010 The wait counter SHALL increment every ACCESS cycle; the cycle where it equals ACCESS_CYCLES-1 is the final access cycle.
REQ-011 On the final read cycle, rd_pix[idx] SHALL be loaded with the converted pixel from r_data.
REQ-012 On every write ACCESS cycle, w_data SHALL equal {wr_pix[idx], wr_pix[idx], wr_pix[idx]}.
REQ-013 After the final access cycle, the FSM SHALL go to DONE if idx=len-1; otherwise it SHALL go to GAP.
REQ-014 GAP SHALL last one cycle with both enables low, address held and busy=1, then increment idx and return to ACCESS with the counter at 0.
REQ-015 DONE SHALL last one cycle with done=1, busy=0 and enables low, then go to IDLE.
REQ-016 Latency: with start sampled in cycle 0, done SHALL be high in cycle N*(ACCESS_CYCLES+1).
REQ-017 rd_pix entries at or above burst_len SHALL keep their previous values.
REQ-018 In IDLE, outputs SHALL be: address holds last value, w_data holds, enables low, busy low.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL enter IDLE, including mid-burst, with no done pulse.
REQ-020 Reset SHALL clear address, w_data, rd_pix (all entries), idx and the counter to 0, and drive busy, done, err, read_enable and write_enable to 0.
REQ-021 rst SHALL take priority over start in the same cycle.

Configuration
REQ-022 With PIXCTRL_GRAYSCALE_EN defined, the read conversion SHALL be:
- s = R+G+B, 10 bits;
- pixel = (s>>2)+(s>>4)+(s>>6)+(s>>8), truncated to 8 bits (maximum 251).
REQ-023 Without PIXCTRL_GRAYSCALE_EN, the read conversion SHALL be pixel = r_data[7:0], with no adder logic present.

Verification
REQ-024 Defaults, macro defined: read, base 0x0100, len 1, r_data=24'h306090 -> address 0x0100 for 12 cycles, rd_pix[0]=0x5F, done in cycle 13.
REQ-025 Macro undefined, same stimulus -> rd_pix[0]=0x90.
REQ-026 Write, base 0x0200, len 3, wr_pix[0..2]=0xAB,0x12,0xFF -> w_data 24'hABABAB, 24'h121212, 24'hFFFFFF at addresses 0x0200 to 0x0202, one GAP cycle between accesses, done in cycle 39.
REQ-027 Read, base 0xFFFF, len 2 -> addresses 0xFFFF then 0x0000.
REQ-028 start with len 0, and separately len 21 -> err pulse, enables never asserted, busy stays low.
REQ-029 rst asserted in cycle 5 of a len-4 read -> next cycle IDLE, enables low, rd_pix all zero, no done; a new start is accepted afterwards.
